program_loader: RTL
===================

// Module: program_loader
// PURPOSE
// - Upstream of the pipelined RV32I core. Receives a byte stream from a host link (UART/debug bridge),
//   assembles little-endian 32-bit instructions and writes them into instruction memory through the
//   core's address/instruction load port.
// - Holds the core's start input low while loading. Raises start once a length-checked,
//   checksum-verified image is complete.
// PARAMETERS
// - BASE_ADDR       32'h0000_0000  byte address of the first instruction word
// - MAX_WORDS       1024           largest accepted image, in 32-bit words
// - TIMEOUT_CYCLES  1000000        idle cycles allowed between accepted bytes before abort
// PORTS
// - clk          in   1   single clock, rising edge
// - rst          in   1   asynchronous, active-high reset
// - load_req     in   1   one-cycle pulse: begin (or restart) a load
// - in_valid     in   1   byte-stream valid
// - in_data      in   8   byte-stream data
// - in_ready     out  1   byte-stream ready; a byte transfers when in_valid && in_ready
// - instr_we     out  1   one-cycle write strobe to instruction memory
// - address      out  32  instruction byte address; drives core ADDRESS
// - instruction  out  32  assembled word; drives core INSTRUCTION
// - start        out  1   core run enable (level)
// - busy         out  1   high in HDR/DATA/CSUM
// - done         out  1   one-cycle pulse on successful load
// - err          out  1   level; high in ERR
// - err_code     out  2   0 none, 1 bad length, 2 checksum, 3 timeout
// - word_count   out  CW  words written so far; CW = $clog2(MAX_WORDS+1)
// BEHAVIOUR
// - Reset: state IDLE. in_ready, instr_we, start, busy, done, err = 0. address, instruction,
//   err_code, word_count = 0. Checksum, byte and timeout counters = 0.
// - Frame format: 4-byte length N (words, LSB first), then 4*N payload bytes (each word LSB first),
//   then 1 checksum byte. The checksum is the XOR of all 4+4N preceding bytes.
// - in_ready = 1 only in HDR/DATA/CSUM, and only while load_req = 0 (combinational gate).
// - IDLE: load_req -> HDR. Clear word_count, checksum, byte counter and err_code.
// - HDR: shift 4 bytes into the length register.
//   - If N == 0 or N > MAX_WORDS -> ERR, code 1.
//   - Otherwise -> DATA.
// - DATA: byte_cnt counts 0..3. The byte lands in lane byte_cnt.
//   - On lane 3 accept, the next cycle has: instr_we = 1, address = BASE_ADDR + 4*word_count
//     (32-bit wrap), instruction = assembled word. word_count increments in that same cycle.
//   - After word N is accepted -> CSUM.
// - CSUM: one byte.
//   - Equal to the running XOR -> RUN, and the next cycle has start = 1 and done = 1 (one cycle).
//   - Not equal -> ERR, code 2. No memory rollback.
// - RUN: start held at 1. load_req -> HDR, and start drops the next cycle.
// - ERR: err = 1, start = 0. Only load_req leaves (-> HDR, err cleared).
// - Timeout: counter clears on every accepted byte and on entry to HDR. It increments every cycle in
//   HDR/DATA/CSUM. Reaching TIMEOUT_CYCLES -> ERR, code 3. A partially assembled word is discarded.
// - load_req in HDR/DATA/CSUM: abort, restart at HDR with all counters cleared. A simultaneous
//   in_valid byte is not accepted (in_ready is gated low).
// - load_req and lane-3 completion in the same cycle: load_req wins. No instr_we for that word.
// - Async rst mid-load: everything returns to reset values immediately. No further instr_we.
// - Exactly one state is active. Ignore in_valid while in_ready = 0.
// STRUCTURE
// - Package rv_loader_pkg:
//   - state enum {IDLE, HDR, DATA, CSUM, RUN, ERR}
//   - err_code localparams ERR_NONE/ERR_LEN/ERR_CSUM/ERR_TIMEOUT
//   - frame constants HDR_BYTES = 4, CSUM_BYTES = 1
// - One sub-module: byte_word_assembler.
//   - Byte-lane counter, shift register, word_ready pulse, sync clear.
// - The FSM, timeout counter, checksum and address generator live in program_loader.
// TESTING
// - Good frame, N = 2, words 32'h00500093, 32'h00108133, csum correct ->
//   instr_we twice: (0x0, 0x00500093) then (0x4, 0x00108133); done pulse; start = 1; word_count = 2.
// - Length 0, and length MAX_WORDS+1 -> ERR, err_code = 1, no instr_we, start = 0.
// - Good N = 1 frame, checksum byte XORed with 8'h01 -> one instr_we, then ERR, err_code = 2, start = 0.
// - Stall 3 bytes into a word, TIMEOUT_CYCLES = 16 in the bench ->
//   ERR with err_code = 3 after exactly 16 idle cycles, no instr_we for the partial word.
// - load_req pulse mid-DATA, in the same cycle as a lane-3 byte ->
//   no strobe for that word, HDR, word_count = 0; the following good frame loads correctly from BASE_ADDR.
// - In RUN, load_req -> start falls next cycle. Assert rst mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rv_loader_pkg.sv
// Shared types and frame constants for the RV32I program loader.
package rv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned HDR_BYTES  = WORD_BYTES;
  localparam int unsigned CSUM_BYTES = 1;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_word_assembler.sv
// Collects little-endian bytes into 32-bit words; pulses word_ready_o the cycle after lane 3
// when emit_i allows it. Used for both the length header and the payload words.
module byte_word_assembler
  import rv_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              emit_i,
  output logic [LANE_W-1:0] lane_o,
  output logic [23:0]       shift_o,
  output logic              word_ready_o,
  output logic [31:0]       word_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic              ready_q, ready_d;
  logic [31:0]       word_q, word_d;
  logic              last_lane;

  assign last_lane = (lane_q == LANE_W'(WORD_BYTES - 1));

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    ready_d = 1'b0;
    word_d  = word_q;
    if (clr_i) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      shift_d = {byte_i, shift_q[23:8]};
      lane_d  = LANE_W'(lane_q + 1'b1);
      if (last_lane && emit_i) begin
        ready_d = 1'b1;
        word_d  = {byte_i, shift_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q  <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
      word_q  <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      word_q  <= word_d;
    end
  end

  assign lane_o       = lane_q;
  assign shift_o      = shift_q;
  assign word_ready_o = ready_q;
  assign word_o       = word_q;

endmodule

// File: rtl/program_loader.sv
// Receives a length/payload/XOR-checksum byte frame and writes it into instruction memory,
// releasing the core's start only after a complete, verified image.
module program_loader
  import rv_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned CW            = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          instr_we,
  output logic [31:0]   address,
  output logic [31:0]   instruction,
  output logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [CW-1:0] word_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       addr_q, addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        errc_q, errc_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              active, accept, lane_last, tmo_hit;
  logic              asm_clr, asm_valid, asm_emit;
  logic [LANE_W-1:0] asm_lane;
  logic [23:0]       asm_shift;
  logic [31:0]       hdr_len;

  // load_req has priority over any byte offered in the same cycle
  assign active    = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign in_ready  = active && !load_req;
  assign accept    = in_valid && in_ready;
  assign asm_valid = accept && (state_q != CSUM);
  assign asm_emit  = (state_q == DATA);
  assign lane_last = (asm_lane == LANE_W'(WORD_BYTES - 1));
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign hdr_len   = {in_data, asm_shift};

  byte_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_valid),
    .byte_i       (in_data),
    .emit_i       (asm_emit),
    .lane_o       (asm_lane),
    .shift_o      (asm_shift),
    .word_ready_o (instr_we),
    .word_o       (instruction)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    errc_d  = errc_q;
    done_d  = 1'b0;
    asm_clr = 1'b0;

    if (active) tmo_d = TMO_W'(tmo_q + 1'b1);
    if (accept) begin
      tmo_d = '0;
      if (state_q != CSUM) csum_d = csum_q ^ in_data;
    end

    case (state_q)
      HDR: begin
        if (accept && lane_last) begin
          if (hdr_len == 32'd0 || hdr_len > 32'(MAX_WORDS)) begin
            state_d = ERR;
            errc_d  = ERR_LEN;
          end else begin
            len_d   = CW'(hdr_len);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept && lane_last) begin
          addr_d = BASE_ADDR + (32'(wcnt_q) << 2);
          wcnt_d = CW'(wcnt_q + 1'b1);
          if (wcnt_q == CW'(len_q - 1'b1)) state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            errc_d  = ERR_CSUM;
          end
        end
      end
      default: ;
    endcase

    if (active && !accept && tmo_hit) begin
      state_d = ERR;
      errc_d  = ERR_TIMEOUT;
    end

    // Any load_req (re)starts the frame from a clean header
    if (load_req) begin
      state_d = HDR;
      wcnt_d  = '0;
      csum_d  = '0;
      tmo_d   = '0;
      errc_d  = ERR_NONE;
      done_d  = 1'b0;
      asm_clr = 1'b1;
    end

    // Drop any partially assembled word on the way into ERR
    if (state_d == ERR && state_q != ERR) asm_clr = 1'b1;

    start_d = (state_d == RUN);
    busy_d  = (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
    err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      tmo_q   <= '0;
      errc_q  <= ERR_NONE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      errc_q  <= errc_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign address    = addr_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = errc_q;
  assign word_count = wcnt_q;

endmodule
